// File: rtl/if_stage_pkg.sv
// Shared constants and types for the Xcore instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [31:0] INST_ADDR_NOP = 32'h0000_0000;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_REQ     = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

endpackage

// File: rtl/if_fifo.sv
// Fetch buffer holding {pc, inst} pairs; read port is the current head, no bypass.
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_ent_t               wdata,
  output fetch_ent_t               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_ent_t       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC generator, single-outstanding ROM handshake, fetch buffer
// and the IF/ID register, with ex redirects and NOP bubble insertion.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_gnt,
  input  logic        rom_rvalid,
  input  logic [31:0] rom_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e   state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        gnt_ok;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_ent_t  fifo_head;
  fetch_ent_t  fifo_wdata;

  // A request is only issued when a buffer slot is free for its response.
  assign rom_req  = !rst && (state == IF_REQ) && (fifo_count < CW'(FIFO_DEPTH));
  assign rom_addr = fetch_pc;
  assign gnt_ok   = rom_req && rom_gnt;

  assign fifo_push  = (state == IF_WAIT) && rom_rvalid && !jump_en && !fifo_full;
  assign fifo_pop   = !jump_en && !stall && !fifo_empty;
  assign fifo_wdata = '{pc: req_pc, inst: rom_rdata};

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (jump_en),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IF_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= ZERO_WORD;
    end else if (jump_en) begin
      fetch_pc <= jump_addr;
      // Any response still owed by memory must be swallowed in DISCARD.
      case (state)
        IF_REQ:  state <= gnt_ok ? IF_DISCARD : IF_REQ;
        default: state <= rom_rvalid ? IF_REQ : IF_DISCARD;
      endcase
    end else begin
      case (state)
        IF_REQ: begin
          if (gnt_ok) begin
            state    <= IF_WAIT;
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        IF_WAIT, IF_DISCARD: if (rom_rvalid) state <= IF_REQ;
        default: state <= IF_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_o   <= INST_ADDR_NOP;
      inst_o <= INST_NOP;
    end else if (jump_en) begin
      pc_o   <= INST_ADDR_NOP;
      inst_o <= INST_NOP;
    end else if (!stall) begin
      if (!fifo_empty) begin
        pc_o   <= fifo_head.pc;
        inst_o <= fifo_head.inst;
      end else begin
        pc_o   <= INST_ADDR_NOP;
        inst_o <= INST_NOP;
      end
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the Xcore 5-stage pipeline. It contains the PC generator, the instruction-memory request handshake, a small fetch buffer, and the IF/ID output register.
- Its pc_o/inst_o feed the id stage's pc/inst inputs directly.
- Handles pipeline stall and branch/jump redirects from ex, and inserts NOP bubbles whenever no fetched instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch-buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset (`RstEnable`).
- stall  in  1  hold the IF/ID output register (id/ex not accepting).
- jump_en  in  1  redirect request from ex (taken branch/jal/jalr).
- jump_addr  in  32  redirect target; bits[1:0] assumed 0 by contract.
- rom_req  out  1  instruction-memory request.
- rom_addr  out  32  request address; stable while rom_req=1 and rom_gnt=0.
- rom_gnt  in  1  request accepted this cycle.
- rom_rvalid  in  1  response valid; exactly one per grant, in order, at least 1 cycle after gnt.
- rom_rdata  in  32  fetched instruction.
- pc_o  out  32  to id.pc.
- inst_o  out  32  to id.inst.

Behaviour:
- Reset (async, rst=1):
  - pc_o = `InstAddrNop` (0) and inst_o = `INST_NOP` (32'h0000_0013).
  - Fetch PC = RESET_PC, FIFO empty, state = REQ, rom_req = 0 while rst is high.
  - Reset mid-transaction abandons any outstanding response. The memory side is also reset by the same rst.
- FSM states: REQ, WAIT, DISCARD. At most one outstanding request.
- REQ:
  - rom_req = 1 when fifo_count < FIFO_DEPTH (the outstanding slot is reserved); rom_addr = fetch PC.
  - On rom_gnt: move to WAIT and latch req_pc = fetch PC; fetch PC += 4 (32-bit wrap from FFFF_FFFC to 0).
- WAIT:
  - rom_req = 0.
  - On rom_rvalid: push {req_pc, rom_rdata} into the FIFO and go to REQ.
  - Best-case throughput is 1 instruction per 2 cycles.
- DISCARD:
  - rom_req = 0.
  - On rom_rvalid: drop the data and go to REQ.
- Redirect (jump_en=1), highest priority, takes effect at the next edge:
  - Fetch PC = jump_addr and the FIFO is cleared.
  - IF/ID register loads pc_o = 0 and inst_o = `INST_NOP`, even if stall=1.
  - Next state depends on the current state:
    - REQ without gnt → REQ. The request is abandoned and the next cycle requests jump_addr.
    - REQ with gnt → DISCARD.
    - WAIT with rvalid → REQ (data dropped).
    - WAIT without rvalid → DISCARD.
    - DISCARD with rvalid → REQ.
    - DISCARD without rvalid → DISCARD.
- IF/ID output register (no jump_en):
  - stall=1: hold pc_o/inst_o; no FIFO pop.
  - stall=0 and FIFO non-empty: pop; pc_o/inst_o = head entry.
  - stall=0 and FIFO empty: load bubble (pc_o = 0, inst_o = `INST_NOP`).
- FIFO:
  - No bypass. An entry pushed at edge N is visible at the output at edge N+1 at the earliest.
  - Simultaneous push and pop are legal; count is unchanged.
  - Push when full cannot occur because of the reservation rule. The bench asserts this.
- Latency: gnt in cycle 0, rvalid in cycle 1 → FIFO write at end of cycle 1 → pc_o/inst_o valid from cycle 3.

Decomposition:
- Add to defines.v:
  - `INST_NOP` 32'h0000_0013.
  - FSM state encodings `IF_REQ`/`IF_WAIT`/`IF_DISCARD` (2 bits).
  - Reuse `RstEnable`, `ZeroWord`, `InstAddrNop`.
- One sub-module, if_fifo:
  - Parameterised depth; 64-bit entries {pc, inst}.
  - Signals: push, pop, clear, full, empty, count.
  - Pointer wrap and clear handled inside.

Test Plan:
- Reset release, rom_gnt tied 1, rvalid 1 cycle after gnt with rdata = addr ^ 32'hA5A5_0000 → pc_o sequence 0, 4, 8, … with matching inst_o; NOP bubbles between fetches; rom_addr never changes while ungranted.
- stall=1 held 6 cycles during streaming → pc_o/inst_o frozen; rom_req drops once 2 entries are buffered plus none outstanding; on release, buffered PCs appear consecutively with no gaps and no duplicates.
- jump_en with jump_addr = 32'h0000_0100 while in WAIT, rvalid arriving 3 cycles later → that response dropped; next rom_addr = 0x100; no stale PC ever reaches pc_o; a NOP is emitted in the redirect cycle.
- jump_en in the same cycle as rom_gnt → DISCARD entered, the granted response dropped, and the following request goes to jump_addr.
- jump_en and stall both high with the FIFO full → FIFO cleared and output forced to NOP (redirect beats stall).
- Async rst asserted mid-WAIT without a clock edge → outputs immediately pc_o = 0, inst_o = 0x13; after release, the first request is to RESET_PC.
